// File: rtl/instr_fetch_buffer_pkg.sv
// Shared constants for the instruction fetch buffer: bus widths and the
// active levels of reset, hold and cancel.
package instr_fetch_buffer_pkg;

  localparam int   INSTR_ADDR_BUS = 32;
  localparam int   INSTR_WORD_W   = 32;

  localparam logic RESET_EN       = 1'b1;
  localparam logic HOLD           = 1'b1;
  localparam logic CANCEL_INSTR   = 1'b1;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Instruction-memory request/response channel plus the decode-side handshake
// of the fetch buffer. The fetch buffer is the master; memory and decode are the slave side.
interface instr_fetch_buffer_if
  import instr_fetch_buffer_pkg::*;
#(
  parameter int ADDR_W  = INSTR_ADDR_BUS,
  parameter int INSTR_W = INSTR_WORD_W
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// Generic DEPTH-entry synchronous FIFO with a synchronous clear; the head word
// reads as zero while the FIFO is empty.
module fetch_fifo
  import instr_fetch_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push & (~full | pop) & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn == RESET_EN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count are,
  // and the head is masked while empty, so stale words can never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage behind the program counter: issues credit-limited requests to
// instruction memory, drops responses made stale by a flush, and queues pc+instruction for decode.
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int ADDR_W  = INSTR_ADDR_BUS,
  parameter int INSTR_W = INSTR_WORD_W,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       cancel_instr_if,
  input  logic                       flush,
  output logic                       hold,
  instr_fetch_buffer_if.master       bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 2;
  localparam int BUF_W = ADDR_W + INSTR_W;

  logic                rst_active;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    drop_cnt;
  logic [OCC_W-1:0]    occupancy;
  logic                credit_ok;
  logic                req_valid;
  logic                accept;
  logic                rsp;
  logic                dropping;
  logic                live;
  logic                id_pop;

  logic [ADDR_W-1:0]   aq_head;
  logic                aq_empty;
  logic                aq_full;
  logic [CNT_W-1:0]    aq_count;

  logic [BUF_W-1:0]    buf_head;
  logic                buf_empty;
  logic                buf_full;
  logic [CNT_W-1:0]    buf_count;

  assign rst_active = (rstn == RESET_EN);

  // Slots still awaiting a dropped response keep their address-queue entry,
  // so they are counted against credits together with live ones.
  assign occupancy = OCC_W'(buf_count) + OCC_W'(inflight) + OCC_W'(drop_cnt);
  assign credit_ok = (occupancy < OCC_W'(DEPTH));

  assign req_valid = ~rst_active & (cancel_instr_if != CANCEL_INSTR) & ~flush & credit_ok;
  assign accept    = req_valid & bus.imem_req_ready;
  assign hold      = accept ? ~HOLD : HOLD;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;

  // A response in a flush cycle belongs to a discarded fetch, as does any
  // response while earlier drops are still outstanding.
  assign rsp      = bus.imem_rsp_valid;
  assign dropping = rsp & (flush | (drop_cnt != '0));
  assign live     = rsp & ~dropping;

  assign id_pop = ~buf_empty & bus.id_ready & ~flush;

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (1'b0),
    .push      (accept),
    .push_data (pc),
    .pop       (rsp),
    .head_data (aq_head),
    .empty     (aq_empty),
    .full      (aq_full),
    .count     (aq_count)
  );

  fetch_fifo #(
    .WIDTH (BUF_W),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (flush),
    .push      (live),
    .push_data ({aq_head, bus.imem_rsp_data}),
    .pop       (id_pop),
    .head_data (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // counter update below reads the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn == RESET_EN) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      inflight <= '0;
      drop_cnt <= drop_cnt + inflight - CNT_W'(rsp);
    end else begin
      inflight <= inflight + CNT_W'(accept) - CNT_W'(live);
      drop_cnt <= drop_cnt - CNT_W'(dropping);
    end
  end

  assign bus.id_valid = ~buf_empty;
  assign bus.id_pc    = buf_head[BUF_W-1:INSTR_W];
  assign bus.id_instr = buf_head[INSTR_W-1:0];

  a_live_not_full: assert property (@(posedge clk) disable iff (rst_active)
    !(live && buf_full));

  a_rsp_has_addr: assert property (@(posedge clk) disable iff (rst_active)
    !(rsp && aq_empty));

  a_accept_has_slot: assert property (@(posedge clk) disable iff (rst_active)
    !(accept && aq_full));

  a_addr_q_tracks: assert property (@(posedge clk) disable iff (rst_active)
    (OCC_W'(aq_count) == OCC_W'(inflight) + OCC_W'(drop_cnt)));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: a queued memory model answers
// requests, and a scoreboard checks every pc/instruction handed to decode.
module tb_instr_fetch_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc;
  logic        cancel_instr_if;
  logic        flush;
  logic        hold;

  instr_fetch_buffer_if bus ();

  instr_fetch_buffer #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .pc              (pc),
    .cancel_instr_if (cancel_instr_if),
    .flush           (flush),
    .hold            (hold),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    acc_total = 0;
  int    rsp_delay = 1;
  logic  mem_rsp_en = 1'b1;
  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    deliv_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {16'hA5A5, addr[15:0]};
  endfunction

  task automatic expect_id(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.instr = i;
    exp_q.push_back(e);
  endtask

  // Memory: one response per cycle, in order, rsp_delay cycles after acceptance.
  initial begin
    pend_t p;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (rstn) begin
        pend_q.delete();
      end else begin
        if (mem_rsp_en && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = instr_of(pend_q[0].addr);
          void'(pend_q.pop_front());
        end
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          p.addr = bus.imem_req_addr;
          p.due  = cyc + rsp_delay;
          pend_q.push_back(p);
          acc_total++;
        end
      end
    end
  end

  always @(posedge rstn) pend_q.delete();

  // Scoreboard monitor: compares every decode handoff against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rstn && bus.id_valid && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL id_unexpected: got pc=%0h instr=%0h, required no delivery", bus.id_pc, bus.id_instr);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", bus.id_pc, e.pc);
          check("id_instr", bus.id_instr, e.instr);
          deliv_cyc.push_back(cyc);
        end
      end
    end
  end

  // Presents addr until accepted; returns at the next negedge with cancel set.
  task automatic fetch(input logic [31:0] addr, output int acc, output int waited);
    int n = 0;
    pc = addr;
    cancel_instr_if = 1'b0;
    #2;
    while (hold && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("fetch_timeout", n >= 40, 0);
    check("req_addr", bus.imem_req_addr, addr);
    acc = cyc;
    waited = n;
    @(negedge clk);
    cancel_instr_if = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, a2, w, base;
    rstn = 1'b1;
    pc = '0;
    cancel_instr_if = 1'b0;
    flush = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    #3;
    check("rst_id_valid", bus.id_valid, 0);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_hold", hold, 1);
    check("rst_id_pc", bus.id_pc, 0);
    check("rst_id_instr", bus.id_instr, 0);
    @(negedge clk);
    rstn = 1'b0;
    cancel_instr_if = 1'b1;
    @(negedge clk);

    // Back-to-back streaming.
    deliv_cyc.delete();
    expect_id(32'h0, 32'hA5A5_0000);
    expect_id(32'h4, 32'hA5A5_0004);
    expect_id(32'h8, 32'hA5A5_0008);
    fetch(32'h0, a0, w);
    fetch(32'h4, a1, w);
    fetch(32'h8, a2, w);
    check("stream_b2b", a2 - a0, 2);
    drain("stream_drain");
    check("stream_count", deliv_cyc.size(), 3);
    if (deliv_cyc.size() >= 3) begin
      check("stream_first_latency", deliv_cyc[0] - a0, 2);
      check("stream_consecutive", deliv_cyc[2] - deliv_cyc[0], 2);
    end

    // Decode stall: credits run out after DEPTH requests.
    bus.id_ready = 1'b0;
    expect_id(32'h20, 32'hA5A5_0020);
    expect_id(32'h24, 32'hA5A5_0024);
    expect_id(32'h28, 32'hA5A5_0028);
    expect_id(32'h2C, 32'hA5A5_002C);
    expect_id(32'h30, 32'hA5A5_0030);
    fetch(32'h20, a0, w);
    fetch(32'h24, a0, w);
    fetch(32'h28, a0, w);
    fetch(32'h2C, a0, w);
    pc = 32'h30;
    cancel_instr_if = 1'b0;
    #2;
    check("stall_req_valid", bus.imem_req_valid, 0);
    check("stall_hold", hold, 1);
    repeat (4) @(negedge clk);
    #2;
    check("stall_still_blocked", bus.imem_req_valid, 0);
    check("stall_id_valid", bus.id_valid, 1);
    @(negedge clk);
    base = acc_total;
    bus.id_ready = 1'b1;
    @(negedge clk);
    bus.id_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_one_request", acc_total - base, 1);
    cancel_instr_if = 1'b1;
    bus.id_ready = 1'b1;
    drain("stall_drain");

    // Cancel holds the pc and issues nothing.
    for (int i = 0; i < 3; i++) begin
      pc = 32'h10;
      cancel_instr_if = 1'b1;
      #2;
      check("cancel_req_valid", bus.imem_req_valid, 0);
      check("cancel_hold", hold, 1);
      @(negedge clk);
    end
    expect_id(32'h10, 32'hA5A5_0010);
    fetch(32'h10, a0, w);
    check("cancel_release_wait", w, 0);
    drain("cancel_drain");

    // Flush with two requests in flight.
    mem_rsp_en = 1'b0;
    fetch(32'h40, a0, w);
    fetch(32'h44, a0, w);
    flush = 1'b1;
    pc = 32'h100;
    cancel_instr_if = 1'b0;
    #2;
    check("flush_req_valid", bus.imem_req_valid, 0);
    check("flush_hold", hold, 1);
    @(negedge clk);
    flush = 1'b0;
    cancel_instr_if = 1'b1;
    bus.imem_req_ready = 1'b0;
    mem_rsp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("flush_id_valid", bus.id_valid, 0);
      @(negedge clk);
    end
    bus.imem_req_ready = 1'b1;
    expect_id(32'h100, 32'hA5A5_0100);
    fetch(32'h100, a0, w);
    drain("flush_drain");

    // Flush in the same cycle as a response, one more response still due.
    rsp_delay = 2;
    fetch(32'h60, a0, w);
    fetch(32'h64, a0, w);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("flush_rsp_id_valid", bus.id_valid, 0);
      @(negedge clk);
    end
    rsp_delay = 1;
    expect_id(32'h200, 32'hA5A5_0200);
    fetch(32'h200, a0, w);
    drain("flush_rsp_drain");

    // Asynchronous reset with the buffer full.
    bus.id_ready = 1'b0;
    fetch(32'h80, a0, w);
    fetch(32'h84, a0, w);
    fetch(32'h88, a0, w);
    fetch(32'h8C, a0, w);
    repeat (4) @(negedge clk);
    pc = 32'h90;
    cancel_instr_if = 1'b0;
    #2;
    check("pre_reset_id_valid", bus.id_valid, 1);
    check("pre_reset_req_valid", bus.imem_req_valid, 0);
    #1;
    rstn = 1'b1;
    #1;
    check("async_rst_id_valid", bus.id_valid, 0);
    check("async_rst_req_valid", bus.imem_req_valid, 0);
    check("async_rst_hold", hold, 1);
    @(negedge clk);
    rstn = 1'b0;
    cancel_instr_if = 1'b1;
    bus.id_ready = 1'b1;
    @(negedge clk);
    expect_id(32'h300, 32'hA5A5_0300);
    fetch(32'h300, a0, w);
    check("post_reset_wait", w, 0);
    drain("post_reset_drain");

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
